// File: rtl/button_debounce_device.sv
// button_debounce_device: memory-mapped front end for four raw buttons.
// Each button is synchronised by two flops and then debounced. The debounce
// counter advances once per prescaler tick, every 2^PRESCALE_BITS clocks.
// Debounced press and release edges are latched into registers whose bits
// are cleared by writing 1 to them. Where a clear and a new edge hit the
// same bit in the same cycle, the edge wins and the bit stays set.
//
// Optional feature macro: BTNDEV_PRESS_COUNT_EN
//   Defined   - register 0x5 counts debounced press edges from all buttons.
//   Undefined - 0x5 reads 0x00, writes to it are ignored, and no counter
//               logic is built.
//
// Register map (low nibble of the device address):
//   0x0 STATE  RO   {4'b0, debounced}
//   0x1 PRESS  W1C  {4'b0, press}
//   0x2 REL    W1C  {4'b0, rel}
//   0x3 EVEN   RW   [3:0] press event enables, [7:4] release event enables
//   0x4 THRESH RW   debounce threshold in ticks (0 behaves as 1)
//   0x5 COUNT  press-edge counter (only with BTNDEV_PRESS_COUNT_EN)
module button_debounce_device #(
  parameter int PRESCALE_BITS = 10,
  parameter int NUM_BUTTONS   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             address,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic [NUM_BUTTONS-1:0] button_state,
  output logic                   event_pending
);

  localparam logic [3:0] ADDR_STATE  = 4'h0;
  localparam logic [3:0] ADDR_PRESS  = 4'h1;
  localparam logic [3:0] ADDR_REL    = 4'h2;
  localparam logic [3:0] ADDR_EVEN   = 4'h3;
  localparam logic [3:0] ADDR_THRESH = 4'h4;
  localparam logic [3:0] ADDR_COUNT  = 4'h5;

  localparam logic [7:0] THRESH_RESET = 8'h10;

  // Synchroniser
  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;

  // Prescaler
  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic                     tick;

  // Debounce
  logic [7:0]             cnt_q [NUM_BUTTONS];
  logic [7:0]             cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] deb_q, deb_d;
  logic [NUM_BUTTONS-1:0] deb_prev_q, deb_prev_d;
  logic [7:0]             thr_eff;

  // Events and configuration
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] rel_q, rel_d;
  logic [NUM_BUTTONS-1:0] rise, fall;
  logic [7:0]             even_q, even_d;
  logic [7:0]             thresh_q, thresh_d;

  // Bus decode
  logic       wr_en;
  logic       rd_en;
  logic       wr_press;
  logic       wr_rel;
  logic       wr_even;
  logic       wr_thresh;
  logic [7:0] rd_data;

`ifdef BTNDEV_PRESS_COUNT_EN
  logic       wr_count;
  logic [7:0] count_q, count_d;
  logic [7:0] rise_cnt;
`endif

  assign wr_en     = enable && mode;
  assign rd_en     = enable && !mode;
  assign wr_press  = wr_en && (address == ADDR_PRESS);
  assign wr_rel    = wr_en && (address == ADDR_REL);
  assign wr_even   = wr_en && (address == ADDR_EVEN);
  assign wr_thresh = wr_en && (address == ADDR_THRESH);
`ifdef BTNDEV_PRESS_COUNT_EN
  assign wr_count  = wr_en && (address == ADDR_COUNT);
`endif

  // Two-flop synchroniser and free-running prescaler.
  // tick is high in the cycle at whose closing edge the prescaler wraps to 0.
  always_comb begin
    sync1_d = button_state;
    sync2_d = sync1_q;
    presc_d = presc_q + 1'b1;
    tick    = (presc_q == {PRESCALE_BITS{1'b1}});
  end

  // Debounce counters: clear whenever the input agrees with the debounced
  // level, otherwise count ticks. On reaching the threshold the level toggles.
  // The compare is >= so that lowering THRESH below a running count fires on
  // the next tick.
  always_comb begin
    thr_eff    = (thresh_q == 8'h00) ? 8'h01 : thresh_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = 8'h00;
      end else if (tick) begin
        if (({1'b0, cnt_q[i]} + 9'd1) >= {1'b0, thr_eff}) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = 8'h00;
        end else if (cnt_q[i] != 8'hFF) begin
          cnt_d[i] = cnt_q[i] + 8'h01;
        end
      end
    end
  end

  // Edge capture against the one-cycle-delayed debounced level. The clear
  // mask is applied first, so a new edge in the same cycle keeps the bit set.
  always_comb begin
    rise    = deb_q & ~deb_prev_q;
    fall    = ~deb_q & deb_prev_q;
    press_d = (press_q & ~(wr_press ? data_in[NUM_BUTTONS-1:0] : '0)) | rise;
    rel_d   = (rel_q & ~(wr_rel ? data_in[NUM_BUTTONS-1:0] : '0)) | fall;
  end

  // Configuration registers.
  always_comb begin
    even_d   = wr_even ? data_in : even_q;
    thresh_d = wr_thresh ? data_in : thresh_q;
  end

`ifdef BTNDEV_PRESS_COUNT_EN
  // Press counter: adds the number of new press edges in this cycle. A write
  // to 0x5 clears it, keeping only the presses that land in the same cycle.
  always_comb begin
    rise_cnt = 8'h00;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      rise_cnt = rise_cnt + {7'b0, rise[i]};
    end
    count_d = wr_count ? rise_cnt : (count_q + rise_cnt);
  end
`endif

  // Combinational read mux; unmapped addresses return 0x00.
  always_comb begin
    rd_data = 8'h00;
    case (address)
      ADDR_STATE:  rd_data = {4'b0, deb_q};
      ADDR_PRESS:  rd_data = {4'b0, press_q};
      ADDR_REL:    rd_data = {4'b0, rel_q};
      ADDR_EVEN:   rd_data = even_q;
      ADDR_THRESH: rd_data = thresh_q;
`ifdef BTNDEV_PRESS_COUNT_EN
      ADDR_COUNT:  rd_data = count_q;
`endif
      default:     rd_data = 8'h00;
    endcase
  end

  // The shared bus is driven only while the device is selected for a read.
  assign data_out = rd_en ? rd_data : 8'bzzzz_zzzz;

  assign event_pending = (|(press_q & even_q[3:0])) | (|(rel_q & even_q[7:4]));

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      even_q     <= 8'h00;
      thresh_q   <= THRESH_RESET;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= 8'h00;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      presc_q    <= presc_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      even_q     <= even_d;
      thresh_q   <= thresh_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef BTNDEV_PRESS_COUNT_EN
  // Press counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end
`endif

endmodule
